// File: rtl/stream_merge_rr.sv
// Round-robin merge of CHANNELS valid/ack streams into one registered output stream.
// Each word takes IDLE -> ACCEPT -> SEND, so the minimum is 3 cycles. Latched exception flags have a maskable summary output.
module stream_merge_rr #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] input_in,
  input  logic [CHANNELS-1:0]       input_in_stb,
  output logic [CHANNELS-1:0]       input_in_ack,
  output logic [WIDTH-1:0]          output_out,
  output logic                      output_out_stb,
  input  logic                      output_out_ack,
  output logic [CH_BITS-1:0]        output_channel,
  input  logic [CHANNELS-1:0]       exception_in,
  input  logic [CHANNELS-1:0]       exception_mask,
  input  logic                      exception_clear,
  output logic                      exception,
  output logic [CHANNELS-1:0]       exception_source
);

  typedef enum logic [1:0] {IDLE, ACCEPT, SEND} state_t;

  state_t             state, state_n;
  logic [CH_BITS-1:0] grant, grant_n;
  logic [CH_BITS-1:0] last_grant;
  logic [CH_BITS-1:0] pick;
  logic               any_req;
  logic               take;

  assign any_req = |input_in_stb;
  assign take    = input_in_stb[grant];

  // Descending scan: the last hit written is the nearest channel after last_grant.
  always_comb begin
    pick = last_grant;
    for (int i = CHANNELS; i >= 1; i--) begin
      if (input_in_stb[(int'(last_grant) + i) % CHANNELS])
        pick = CH_BITS'((int'(last_grant) + i) % CHANNELS);
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n = ACCEPT;
          grant_n = pick;
        end
      end
      ACCEPT:  state_n = take ? SEND : IDLE;
      SEND:    if (output_out_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_in_ack   <= '0;
      output_out     <= '0;
      output_out_stb <= 1'b0;
      output_channel <= '0;
      last_grant     <= CH_BITS'(CHANNELS - 1);
    end else begin
      input_in_ack <= '0;
      if (state == IDLE && any_req)
        input_in_ack <= CHANNELS'(1) << pick;
      if (state == ACCEPT && take) begin
        output_out     <= input_in[int'(grant)*WIDTH +: WIDTH];
        output_channel <= grant;
        last_grant     <= grant;
        output_out_stb <= 1'b1;
      end else if (state == SEND && output_out_ack) begin
        output_out_stb <= 1'b0;
      end
    end
  end

  // A new exception on a bit wins over a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exception_source <= '0;
      exception        <= 1'b0;
    end else begin
      exception_source <= (exception_source & ~{CHANNELS{exception_clear}}) | exception_in;
      exception        <= |(exception_source & ~exception_mask);
    end
  end

endmodule
